chain_relax_core: RTL and testbench

CHAIN_RELAX_CORE -- requirements
Module: chain_relax_core

---
 rtl/chain_relax_core.sv | 207 ++++++++++++++++++++
 tb/tb_chain_relax_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_relax_core.sv
`default_nettype none
// ============================================================================
//  Module   : chain_relax_core
//  Purpose  : One segment of a rope/chain simulation. Each step applies
//             gravity to every free node, then runs ITERS Gauss-Seidel
//             relaxation passes, one node per cycle, in ascending order.
//             Node 0 of core 1 is pinned and follows the mouse target.
//  Ports    : clk, reset (sync, active-low)
//             step_valid / step_ready   : step request handshake
//             mouse_valid, x/y_mouse    : pinned-node target (latched on accept)
//             prev_last_x/y             : last node of the previous core
//             next_first_x/y            : first node of the next core
//             is_last                   : this core terminates the chain
//             nodes_x/y                 : packed node positions, node i at [i*W +: W]
//             busy, done (1-cycle pulse), step_count (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module chain_relax_core #(
   parameter int              NODES   = 5,
   parameter int              W       = 32,
   parameter int              CORE_ID = 1,
   parameter int              ITERS   = 4,
   parameter logic [W-1:0]    SEG_LEN = 16,
   parameter logic [W-1:0]    GRAVITY = 1,
   parameter logic [W-1:0]    X0      = 0,
   parameter logic [W-1:0]    Y0      = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step_valid,
   output logic                 step_ready,
   input  logic                 mouse_valid,
   input  logic [W-1:0]         x_mouse,
   input  logic [W-1:0]         y_mouse,
   input  logic [W-1:0]         prev_last_x,
   input  logic [W-1:0]         prev_last_y,
   input  logic [W-1:0]         next_first_x,
   input  logic [W-1:0]         next_first_y,
   input  logic                 is_last,
   output logic [NODES*W-1:0]   nodes_x,
   output logic [NODES*W-1:0]   nodes_y,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          step_count
);

   localparam int        IW        = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int        PW        = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam bit        HAS_PIN   = (CORE_ID == 1);
   localparam [IW-1:0]   IDX_LAST  = IW'(NODES - 1);
   localparam [PW-1:0]   PASS_LAST = PW'(ITERS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRAV  = 2'd1,
      RELAX = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [PW-1:0]   pass;
   logic            m_valid;
   logic [W-1:0]    m_x;
   logic [W-1:0]    m_y;
   logic [W-1:0]    pos_x [NODES];
   logic [W-1:0]    pos_y [NODES];

   // Neighbour tables: entry j holds the prev/next neighbour of node j.
   // Chain ends fall through to the adjacent cores' live boundary inputs.
   logic [W-1:0]    nb_px [NODES];
   logic [W-1:0]    nb_py [NODES];
   logic [W-1:0]    nb_nx [NODES];
   logic [W-1:0]    nb_ny [NODES];

   logic [W-1:0]    cur_px, cur_py, cur_nx, cur_ny;
   logic [W:0]      sum_x, sum_y;
   logic [W-1:0]    new_x, new_y;

   // Reset x position: nodes are laid out SEG_LEN apart along the whole
   // chain, so each core starts where the previous core's nodes ended.
   function automatic logic [W-1:0] init_x(input int i);
      logic [W-1:0] k;
      k = W'((CORE_ID - 1) * NODES + i);
      return X0 + k * SEG_LEN;
   endfunction

   // Add GRAVITY with clamping to the signed W-bit range.
   function automatic logic [W-1:0] add_gravity(input logic [W-1:0] v);
      logic [W:0] s;
      s = {v[W-1], v} + {GRAVITY[W-1], GRAVITY};
      if (s[W] != s[W-1])
         return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return s[W-1:0];
   endfunction

   for (genvar j = 0; j < NODES; j++) begin : g_nb
      if (j == 0) begin : g_first
         assign nb_px[j] = prev_last_x;
         assign nb_py[j] = prev_last_y;
      end else begin : g_mid_p
         assign nb_px[j] = pos_x[j-1];
         assign nb_py[j] = pos_y[j-1];
      end
      if (j == NODES - 1) begin : g_last
         assign nb_nx[j] = next_first_x;
         assign nb_ny[j] = next_first_y;
      end else begin : g_mid_n
         assign nb_nx[j] = pos_x[j+1];
         assign nb_ny[j] = pos_y[j+1];
      end
   end

   // Candidate update for node idx. The sum is one bit wider so the
   // midpoint never overflows; dropping bit 0 is an arithmetic shift.
   always_comb begin
      cur_px = nb_px[idx];
      cur_py = nb_py[idx];
      cur_nx = nb_nx[idx];
      cur_ny = nb_ny[idx];
      sum_x  = {cur_px[W-1], cur_px} + {cur_nx[W-1], cur_nx};
      sum_y  = {cur_py[W-1], cur_py} + {cur_ny[W-1], cur_ny};
      if (is_last && (idx == IDX_LAST)) begin
         new_x = cur_px;
         new_y = cur_py + SEG_LEN;
      end else begin
         new_x = sum_x[W:1];
         new_y = sum_y[W:1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         pass       <= '0;
         done       <= 1'b0;
         step_count <= 16'd0;
         m_valid    <= 1'b0;
         m_x        <= '0;
         m_y        <= '0;
         for (int i = 0; i < NODES; i++) begin
            pos_x[i] <= init_x(i);
            pos_y[i] <= Y0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (step_valid) begin
                  m_valid <= mouse_valid;
                  m_x     <= x_mouse;
                  m_y     <= y_mouse;
                  state   <= GRAV;
               end
            end
            GRAV: begin
               for (int i = 0; i < NODES; i++) begin
                  if (HAS_PIN && (i == 0)) begin
                     if (m_valid) begin
                        pos_x[i] <= m_x;
                        pos_y[i] <= m_y;
                     end
                  end else begin
                     pos_y[i] <= add_gravity(pos_y[i]);
                  end
               end
               idx   <= '0;
               pass  <= '0;
               state <= RELAX;
            end
            RELAX: begin
               // The pinned node keeps its slot in the schedule but is not written.
               if (!(HAS_PIN && (idx == '0))) begin
                  pos_x[idx] <= new_x;
                  pos_y[idx] <= new_y;
               end
               if (idx == IDX_LAST) begin
                  idx <= '0;
                  if (pass == PASS_LAST)
                     state <= DONE;
                  else
                     pass <= pass + 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done       <= 1'b1;
               step_count <= step_count + 16'd1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign step_ready = (state == IDLE);
   assign busy       = !step_ready;

   for (genvar i = 0; i < NODES; i++) begin : g_out
      assign nodes_x[i*W +: W] = pos_x[i];
      assign nodes_y[i*W +: W] = pos_y[i];
   end

endmodule
`default_nettype wire

// File: tb/tb_chain_relax_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chain_relax_core
//  Purpose  : Self-checking bench for chain_relax_core. Two cores with
//             different parameter sets share one stimulus stream; each has a
//             step-level reference model that precomputes the per-cycle
//             position snapshots of a step when it is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chain_relax_core;

   localparam int NI = 2;
   localparam int NN = 5;
   localparam int WW = 32;
   localparam int BW = NN * WW;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        step_valid = 1'b0;
   logic        mouse_valid = 1'b0;
   logic        is_last = 1'b0;
   logic [31:0] x_mouse = '0, y_mouse = '0;
   logic [31:0] prev_last_x = '0, prev_last_y = '0;
   logic [31:0] next_first_x = '0, next_first_y = '0;

   logic [BW-1:0] nx [NI];
   logic [BW-1:0] ny [NI];
   logic          ready_s [NI];
   logic          busy_s [NI];
   logic          done_s [NI];
   logic [15:0]   cnt_s [NI];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Midpoint rounded toward minus infinity.
   function automatic logic [31:0] avg(input logic signed [31:0] a, input logic signed [31:0] b);
      longint s;
      s = longint'(a) + longint'(b);
      return 32'(s >>> 1);
   endfunction

   function automatic logic [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] g);
      longint s;
      s = longint'(a) + longint'(g);
      if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
      if (s < -64'sd2147483648) return 32'h80000000;
      return 32'(s);
   endfunction

   function automatic logic [31:0] rnd_coord();
      case ($urandom % 4)
         0:       return $urandom;
         1:       return 32'($urandom_range(400)) - 32'd200;
         2:       return 32'h7FFFFF00 + 32'($urandom_range(255));
         default: return 32'h80000000 + 32'($urandom_range(255));
      endcase
   endfunction

   for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int                 ITR = (k == 0) ? 1 : 2;
      localparam int                 CID = (k == 0) ? 1 : 2;
      localparam logic signed [31:0] GRV = (k == 0) ? 32'sd0 : 32'sd1;
      localparam logic signed [31:0] Y0P = (k == 0) ? 32'sd0 : 32'sh7FFFFFFF;
      localparam logic signed [31:0] SEG = 32'sd16;
      localparam int                 LAT = NN * ITR + 2;

      chain_relax_core #(
         .NODES(NN), .W(WW), .CORE_ID(CID), .ITERS(ITR),
         .SEG_LEN(SEG), .GRAVITY(GRV), .X0(32'sd0), .Y0(Y0P)
      ) dut (
         .clk(clk), .reset(reset),
         .step_valid(step_valid), .step_ready(ready_s[k]),
         .mouse_valid(mouse_valid), .x_mouse(x_mouse), .y_mouse(y_mouse),
         .prev_last_x(prev_last_x), .prev_last_y(prev_last_y),
         .next_first_x(next_first_x), .next_first_y(next_first_y),
         .is_last(is_last),
         .nodes_x(nx[k]), .nodes_y(ny[k]),
         .busy(busy_s[k]), .done(done_s[k]), .step_count(cnt_s[k])
      );

      // Model state: committed positions, and the snapshot sequence of the
      // step in flight (index = cycles elapsed since the accept edge).
      logic signed [31:0] cx [NN];
      logic signed [31:0] cy [NN];
      logic signed [31:0] sx [LAT][NN];
      logic signed [31:0] sy [LAT][NN];
      int                 t = -1;
      logic [15:0]        ecnt = '0;
      logic               edone = 1'b0;
      logic               armed = 1'b0;

      always @(posedge clk) begin
         logic signed [31:0] x [NN];
         logic signed [31:0] y [NN];
         logic signed [31:0] px, py, qx, qy;
         int s;
         if (!reset) begin
            for (int i = 0; i < NN; i++) begin
               cx[i] = 32'(((CID - 1) * NN + i) * 16);
               cy[i] = Y0P;
            end
            t = -1; ecnt = '0; edone = 1'b0; armed = 1'b1;
         end else begin
            edone = 1'b0;
            if (t < 0) begin
               if (step_valid) begin
                  for (int i = 0; i < NN; i++) begin
                     x[i] = cx[i]; y[i] = cy[i];
                     sx[0][i] = x[i]; sy[0][i] = y[i];
                  end
                  for (int i = 0; i < NN; i++) begin
                     if (CID == 1 && i == 0) begin
                        if (mouse_valid) begin x[i] = x_mouse; y[i] = y_mouse; end
                     end else begin
                        y[i] = sat_add(y[i], GRV);
                     end
                  end
                  for (int i = 0; i < NN; i++) begin sx[1][i] = x[i]; sy[1][i] = y[i]; end
                  s = 2;
                  for (int p = 0; p < ITR; p++) begin
                     for (int i = 0; i < NN; i++) begin
                        if (!(CID == 1 && i == 0)) begin
                           px = (i == 0) ? prev_last_x : x[(i == 0) ? 0 : i - 1];
                           py = (i == 0) ? prev_last_y : y[(i == 0) ? 0 : i - 1];
                           qx = (i == NN - 1) ? next_first_x : x[(i == NN - 1) ? i : i + 1];
                           qy = (i == NN - 1) ? next_first_y : y[(i == NN - 1) ? i : i + 1];
                           if (i == NN - 1 && is_last) begin
                              x[i] = px; y[i] = py + SEG;
                           end else begin
                              x[i] = avg(px, qx); y[i] = avg(py, qy);
                           end
                        end
                        for (int n = 0; n < NN; n++) begin sx[s][n] = x[n]; sy[s][n] = y[n]; end
                        s++;
                     end
                  end
                  t = 0;
               end
            end else begin
               t++;
               if (t == LAT) begin
                  for (int i = 0; i < NN; i++) begin
                     cx[i] = sx[LAT-1][i]; cy[i] = sy[LAT-1][i];
                  end
                  edone = 1'b1;
                  ecnt  = ecnt + 16'd1;
                  t     = -1;
               end
            end
         end
      end

      always @(negedge clk) begin
         logic [BW-1:0] ex, ey;
         if (armed) begin
            for (int i = 0; i < NN; i++) begin
               ex[i*32 +: 32] = (t < 0) ? cx[i] : sx[(t < 0) ? 0 : t][i];
               ey[i*32 +: 32] = (t < 0) ? cy[i] : sy[(t < 0) ? 0 : t][i];
            end
            chk($sformatf("inst%0d nodes_x", k), nx[k], ex);
            chk($sformatf("inst%0d nodes_y", k), ny[k], ey);
            chk($sformatf("inst%0d busy", k), BW'(busy_s[k]), BW'(t >= 0));
            chk($sformatf("inst%0d step_ready", k), BW'(ready_s[k]), BW'(t < 0));
            chk($sformatf("inst%0d done", k), BW'(done_s[k]), BW'(edone));
            chk($sformatf("inst%0d step_count", k), BW'(cnt_s[k]), BW'(ecnt));
         end
      end
   end

   initial begin
      int lat;
      int pulses;

      // Reset values
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset nodes_x", nx[0], {32'd64, 32'd48, 32'd32, 32'd16, 32'd0});
      chk("reset nodes_y", ny[0], '0);
      chk("reset step_ready", BW'(ready_s[0]), BW'(1));
      chk("reset busy", BW'(busy_s[0]), '0);
      chk("reset step_count", BW'(cnt_s[0]), '0);
      chk("reset core2 nodes_x", nx[1], {32'd144, 32'd128, 32'd112, 32'd96, 32'd80});
      reset = 1'b1;

      // Pinned node to origin with a free end; core 2 checks saturation and floor rounding
      is_last = 1'b1; mouse_valid = 1'b1; x_mouse = '0; y_mouse = '0;
      prev_last_x = 32'hFFFFFF9D; prev_last_y = 32'h7FFFFFFF;
      next_first_x = '0; next_first_y = '0;
      step_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      step_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("gravity saturation", ny[1], {5{32'h7FFFFFFF}});
      @(posedge clk); @(negedge clk);
      chk("core2 node0 floor avg", BW'(nx[1][31:0]), BW'(32'hFFFFFFFE));
      lat = 2;
      while (!done_s[0] && lat < 40) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      chk("done latency", BW'(lat), BW'(7));
      chk("step nodes_x", nx[0], {32'd48, 32'd48, 32'd32, 32'd16, 32'd0});
      chk("step nodes_y", ny[0], {32'd16, 32'd0, 32'd0, 32'd0, 32'd0});
      chk("step step_count", BW'(cnt_s[0]), BW'(1));

      // Reset during the third RELAX cycle
      repeat (16) @(negedge clk);
      step_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      step_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      chk("abort nodes_x", nx[0], {32'd64, 32'd48, 32'd32, 32'd16, 32'd0});
      chk("abort step_count", BW'(cnt_s[0]), '0);
      chk("abort busy", BW'(busy_s[0]), '0);
      pulses = 0;
      repeat (10) begin
         @(posedge clk); @(negedge clk);
         if (done_s[0]) pulses++;
      end
      chk("abort no done", BW'(pulses), '0);

      // step_valid held high for 20 cycles
      step_valid = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         if (done_s[0]) pulses++;
      end
      step_valid = 1'b0;
      chk("held step done pulses", BW'(pulses), BW'(2));

      // Randomized phase: boundary inputs only change while both cores are idle
      for (int it = 0; it < 40; it++) begin
         step_valid = 1'b0;
         reset = 1'b1;
         repeat (14) @(negedge clk);
         mouse_valid  = 1'($urandom % 2);
         x_mouse      = rnd_coord();
         y_mouse      = rnd_coord();
         prev_last_x  = rnd_coord();
         prev_last_y  = rnd_coord();
         next_first_x = rnd_coord();
         next_first_y = rnd_coord();
         is_last      = 1'($urandom % 2);
         repeat (30) begin
            step_valid = (($urandom % 3) != 0);
            reset      = (($urandom % 50) != 0);
            @(negedge clk);
         end
      end
      step_valid = 1'b0;
      reset = 1'b1;
      repeat (14) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
